simple_uart: RTL and testbench
==============================

Name: simple_uart

Overview:
- Memory-mapped 8N1 UART peripheral for the PicoRV32 SoC.
- Exposes two registers to the CPU bus:
  - a 32-bit clock divider register;
  - a data register: write = transmit a byte, read = pop the received byte.
- Single clock domain. The CPU bus stalls on `reg_dat_wait` while the transmitter is busy.

Parameters:
- DEFAULT_DIV, 1, reset value of the divider register (bit timing reference).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- resetn, input, 1, synchronous, active-low reset.
- ser_tx, output, 1, serial transmit line; idles high.
- ser_rx, input, 1, serial receive line; idles high. Already synchronous to clk; no synchroniser is required in this block.
- reg_div_we, input, 4, byte-lane write enables for the divider register.
- reg_div_di, input, 32, divider write data.
- reg_div_do, output, 32, current divider value.
- reg_dat_we, input, 1, transmit-byte request.
- reg_dat_re, input, 1, read strobe; clears the receive-buffer valid flag.
- reg_dat_di, input, 32, transmit data; only bits [7:0] are used.
- reg_dat_do, output, 32, receive data.
- reg_dat_wait, output, 1, stall indication for the transmit write.

Behaviour:
- **Divider register (`cfg_divider`, 32 bits)**
  - Reset value: DEFAULT_DIV.
  - Each byte lane i is updated from `reg_div_di[8i+7:8i]` when `reg_div_we[i]` = 1.
  - `reg_div_do` = `cfg_divider` (combinational).
  - Bit period (Tbit) = `cfg_divider` + 2 clocks.
- **Transmitter state**
  - 10-bit shift register `send_pattern`, 4-bit `send_bitcnt`, 32-bit `send_divcnt`, flag `send_dummy`.
  - `ser_tx` = `send_pattern[0]`.
  - Reset: `send_pattern` = all ones, `send_bitcnt` = 0, `send_divcnt` = 0, `send_dummy` = 1. So `ser_tx` = 1 after reset.
  - Any `reg_div_we` bit set → `send_dummy` set to 1, unless the same cycle's priority-1 branch clears it.
  - `send_divcnt` increments every cycle unless reloaded.
- **Transmitter update, each clock (priority order)**
  1. `send_dummy` && `send_bitcnt` == 0: load all ones, `send_bitcnt` = 15, `send_divcnt` = 0, clear `send_dummy`. This is 15 idle bit-times of line settling.
  2. `reg_dat_we` && `send_bitcnt` == 0: load {1, `reg_dat_di[7:0]`, 0}, `send_bitcnt` = 10, `send_divcnt` = 0. Line order: start bit, 8 data bits LSB first, stop bit.
  3. `send_divcnt` > `cfg_divider` && `send_bitcnt` != 0: `send_pattern` = {1, `send_pattern[9:1]`}, decrement `send_bitcnt`, `send_divcnt` = 0.
- **Transmit handshake**
  - `reg_dat_wait` = `reg_dat_we` && (`send_bitcnt` != 0 || `send_dummy`), combinational.
  - The bus holds `reg_dat_we` until `reg_dat_wait` drops. The byte is accepted in the cycle where `reg_dat_we` = 1 and `reg_dat_wait` = 0.
- **Receiver state**
  - States 0..10, 32-bit `recv_divcnt`, 8-bit `recv_pattern`, 8-bit `recv_buf_data`, flag `recv_buf_valid`.
  - Reset: all zero.
  - `recv_divcnt` increments every cycle unless cleared.
  - `reg_dat_re` clears `recv_buf_valid`. A completion in the same cycle wins (valid set).
- **Receiver state transitions**
  - State 0: `recv_divcnt` = 0; if `ser_rx` == 0 go to 1.
  - State 1: when 2·`recv_divcnt` > `cfg_divider` (start-bit midpoint), go to 2 and clear `recv_divcnt`.
  - States 2–9: when `recv_divcnt` > `cfg_divider`, `recv_pattern` = {`ser_rx`, `recv_pattern[7:1]`}, next state, clear `recv_divcnt`.
  - State 10: when `recv_divcnt` > `cfg_divider`, `recv_buf_data` = `recv_pattern`, `recv_buf_valid` = 1, go to 0.
  - The stop bit is not checked (no framing error).
  - A new byte overwrites an unread one (no overrun flag).
- **Receive read data**
  - `reg_dat_do` = `recv_buf_valid` ? {24'b0, `recv_buf_data`} : 32'hFFFF_FFFF.
- **Reset mid-frame**: aborts both directions immediately; `ser_tx` returns high the next cycle.

Test Plan:
- Reset with DEFAULT_DIV=1, no activity:
  - `ser_tx` = 1, `reg_div_do` = 1, `reg_dat_do` = 32'hFFFF_FFFF.
  - `reg_dat_wait` = 1 if `reg_dat_we` is asserted within the first 45 clocks (15·3 dummy period).
- Write `reg_div_we`=4'b0001, di=32'h04 after dummy completes:
  - `reg_div_do` = 4; a new 15-bit dummy starts.
  - Holding `reg_dat_we` gives `reg_dat_wait` = 1 for 90 clocks (15·6).
- Divider=4, idle, write `reg_dat_di`=0x55:
  - `ser_tx` sequence 0,1,0,1,0,1,0,1,0,1, each level held 6 clocks, then stays 1.
  - A second write during the frame sees `reg_dat_wait` = 1 until the frame ends.
- Divider=4, drive `ser_rx` frame for 0xA3 with 6-clock bits:
  - After the stop-bit sample, `reg_dat_do` = 32'h0000_00A3.
  - Pulse `reg_dat_re` → next cycle `reg_dat_do` = 32'hFFFF_FFFF.
- Two back-to-back received frames 0x11 then 0x22 without a read: `reg_dat_do` = 0x22.
- Assert resetn=0 mid-transmit, release:
  - `ser_tx` = 1, divider = DEFAULT_DIV, `recv_buf_valid` = 0, dummy period restarts.

Source files
------------

// File: rtl/simple_uart.sv
// rtl/simple_uart.sv - memory-mapped 8N1 UART with programmable bit divider
// Single clock domain; bus stalls on reg_dat_wait while the transmitter is busy.
module simple_uart #(
  parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  typedef enum logic [3:0] {
    RX_IDLE  = 4'd0,
    RX_START = 4'd1,
    RX_D0    = 4'd2,
    RX_D1    = 4'd3,
    RX_D2    = 4'd4,
    RX_D3    = 4'd5,
    RX_D4    = 4'd6,
    RX_D5    = 4'd7,
    RX_D6    = 4'd8,
    RX_D7    = 4'd9,
    RX_STOP  = 4'd10
  } rx_state_e;

  logic [31:0] cfg_divider_q, cfg_divider_d;

  logic [9:0]  send_pattern_q, send_pattern_d;
  logic [3:0]  send_bitcnt_q, send_bitcnt_d;
  logic [31:0] send_divcnt_q, send_divcnt_d;
  logic        send_dummy_q, send_dummy_d;

  rx_state_e   recv_state_q, recv_state_d;
  logic [31:0] recv_divcnt_q, recv_divcnt_d;
  logic [7:0]  recv_pattern_q, recv_pattern_d;
  logic [7:0]  recv_buf_data_q, recv_buf_data_d;
  logic        recv_buf_valid_q, recv_buf_valid_d;

  logic        unused_dat_hi;
  assign unused_dat_hi = ^reg_dat_di[31:8];

  assign ser_tx       = send_pattern_q[0];
  assign reg_div_do   = cfg_divider_q;
  assign reg_dat_do   = recv_buf_valid_q ? {24'd0, recv_buf_data_q} : 32'hFFFF_FFFF;
  assign reg_dat_wait = reg_dat_we && ((send_bitcnt_q != 4'd0) || send_dummy_q);

  always_comb begin
    cfg_divider_d = cfg_divider_q;
    for (int i = 0; i < 4; i++) begin
      if (reg_div_we[i]) cfg_divider_d[8*i +: 8] = reg_div_di[8*i +: 8];
    end
  end

  always_comb begin
    send_pattern_d = send_pattern_q;
    send_bitcnt_d  = send_bitcnt_q;
    send_divcnt_d  = send_divcnt_q + 32'd1;
    send_dummy_d   = send_dummy_q;
    // A divider change re-settles the line, but an in-progress settle start wins.
    if (|reg_div_we) send_dummy_d = 1'b1;

    if (send_dummy_q && (send_bitcnt_q == 4'd0)) begin
      send_pattern_d = '1;
      send_bitcnt_d  = 4'd15;
      send_divcnt_d  = 32'd0;
      send_dummy_d   = 1'b0;
    end else if (reg_dat_we && (send_bitcnt_q == 4'd0)) begin
      send_pattern_d = {1'b1, reg_dat_di[7:0], 1'b0};
      send_bitcnt_d  = 4'd10;
      send_divcnt_d  = 32'd0;
    end else if ((send_divcnt_q > cfg_divider_q) && (send_bitcnt_q != 4'd0)) begin
      send_pattern_d = {1'b1, send_pattern_q[9:1]};
      send_bitcnt_d  = send_bitcnt_q - 4'd1;
      send_divcnt_d  = 32'd0;
    end
  end

  always_comb begin
    recv_state_d     = recv_state_q;
    recv_divcnt_d    = recv_divcnt_q + 32'd1;
    recv_pattern_d   = recv_pattern_q;
    recv_buf_data_d  = recv_buf_data_q;
    recv_buf_valid_d = reg_dat_re ? 1'b0 : recv_buf_valid_q;

    case (recv_state_q)
      RX_IDLE: begin
        recv_divcnt_d = 32'd0;
        if (!ser_rx) recv_state_d = RX_START;
      end
      RX_START: begin
        // Half a bit period lands the data samples mid-bit.
        if ({recv_divcnt_q, 1'b0} > {1'b0, cfg_divider_q}) begin
          recv_state_d  = RX_D0;
          recv_divcnt_d = 32'd0;
        end
      end
      RX_STOP: begin
        if (recv_divcnt_q > cfg_divider_q) begin
          recv_buf_data_d  = recv_pattern_q;
          recv_buf_valid_d = 1'b1;
          recv_state_d     = RX_IDLE;
        end
      end
      default: begin
        if (recv_divcnt_q > cfg_divider_q) begin
          recv_pattern_d = {ser_rx, recv_pattern_q[7:1]};
          recv_state_d   = rx_state_e'(recv_state_q + 4'd1);
          recv_divcnt_d  = 32'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_divider_q    <= DEFAULT_DIV;
      send_pattern_q   <= '1;
      send_bitcnt_q    <= 4'd0;
      send_divcnt_q    <= 32'd0;
      send_dummy_q     <= 1'b1;
      recv_state_q     <= RX_IDLE;
      recv_divcnt_q    <= 32'd0;
      recv_pattern_q   <= 8'd0;
      recv_buf_data_q  <= 8'd0;
      recv_buf_valid_q <= 1'b0;
    end else begin
      cfg_divider_q    <= cfg_divider_d;
      send_pattern_q   <= send_pattern_d;
      send_bitcnt_q    <= send_bitcnt_d;
      send_divcnt_q    <= send_divcnt_d;
      send_dummy_q     <= send_dummy_d;
      recv_state_q     <= recv_state_d;
      recv_divcnt_q    <= recv_divcnt_d;
      recv_pattern_q   <= recv_pattern_d;
      recv_buf_data_q  <= recv_buf_data_d;
      recv_buf_valid_q <= recv_buf_valid_d;
    end
  end

endmodule

// File: tb/tb_simple_uart.sv
// tb/tb_simple_uart.sv - directed self-checking bench for simple_uart
module tb_simple_uart;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_tx;
  logic        ser_rx = 1'b1;
  logic [3:0]  reg_div_we = 4'd0;
  logic [31:0] reg_div_di = 32'd0;
  logic [31:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = 32'd0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int checks = 0;
  int failures = 0;

  simple_uart #(.DEFAULT_DIV(32'd1)) dut (
    .clk(clk), .resetn(resetn), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reg_dat_wait is combinational: raise the request briefly without crossing an edge.
  task automatic probe_wait(output logic w);
    reg_dat_we = 1'b1;
    #1;
    w = reg_dat_wait;
    reg_dat_we = 1'b0;
  endtask

  task automatic count_busy(output int n);
    logic w;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      probe_wait(w);
      if (!w) break;
      n++;
      tick();
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (6) tick();
    end
    ser_rx = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    checks++;
    if (ser_tx !== 1'b1) begin failures++; $display("FAIL reset_ser_tx got=%b exp=1", ser_tx); end
    checks++;
    if (reg_div_do !== 32'd1) begin failures++; $display("FAIL reset_div got=%h exp=00000001", reg_div_do); end
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_dat_do got=%h exp=ffffffff", reg_dat_do); end
    count_busy(n);
    checks++;
    if (n != 46) begin failures++; $display("FAIL reset_dummy_wait got=%0d exp=46", n); end
  endtask

  task automatic test_div_write();
    int n;
    reg_div_we = 4'b0001;
    reg_div_di = 32'h0000_0004;
    tick();
    reg_div_we = 4'b0000;
    checks++;
    if (reg_div_do !== 32'd4) begin failures++; $display("FAIL div_write got=%h exp=00000004", reg_div_do); end
    count_busy(n);
    checks++;
    if (n != 91) begin failures++; $display("FAIL div_dummy_wait got=%0d exp=91", n); end
  endtask

  task automatic test_div_lanes();
    int n;
    reg_div_we = 4'b1010;
    reg_div_di = 32'h1234_5678;
    tick();
    checks++;
    if (reg_div_do !== 32'h1200_5604) begin failures++; $display("FAIL div_lanes got=%h exp=12005604", reg_div_do); end
    reg_div_we = 4'b1111;
    reg_div_di = 32'h0000_0004;
    tick();
    reg_div_we = 4'b0000;
    checks++;
    if (reg_div_do !== 32'd4) begin failures++; $display("FAIL div_full got=%h exp=00000004", reg_div_do); end
    count_busy(n);
    checks++;
    if (n != 90) begin failures++; $display("FAIL div_lanes_wait got=%0d exp=90", n); end
  endtask

  task automatic test_tx();
    logic [9:0] pat;
    logic       w;
    logic       exp_tx;
    pat = {1'b1, 8'h55, 1'b0};
    reg_dat_di = 32'hABCD_EF55;
    reg_dat_we = 1'b1;
    #1;
    checks++;
    if (reg_dat_wait !== 1'b0) begin failures++; $display("FAIL tx_accept_wait got=%b exp=0", reg_dat_wait); end
    tick();
    reg_dat_we = 1'b0;
    for (int k = 0; k < 70; k++) begin
      exp_tx = (k < 60) ? pat[k / 6] : 1'b1;
      checks++;
      if (ser_tx !== exp_tx) begin failures++; $display("FAIL tx_bit k=%0d got=%b exp=%b", k, ser_tx, exp_tx); end
      probe_wait(w);
      checks++;
      if (w !== (k < 60)) begin failures++; $display("FAIL tx_busy k=%0d got=%b exp=%b", k, w, (k < 60)); end
      tick();
    end
  endtask

  task automatic test_rx();
    send_rx_frame(8'hA3);
    checks++;
    if (reg_dat_do !== 32'h0000_00A3) begin failures++; $display("FAIL rx_data got=%h exp=000000a3", reg_dat_do); end
    reg_dat_re = 1'b1;
    tick();
    reg_dat_re = 1'b0;
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rx_read_clear got=%h exp=ffffffff", reg_dat_do); end
  endtask

  task automatic test_back_to_back();
    send_rx_frame(8'h11);
    checks++;
    if (reg_dat_do !== 32'h0000_0011) begin failures++; $display("FAIL b2b_first got=%h exp=00000011", reg_dat_do); end
    send_rx_frame(8'h22);
    checks++;
    if (reg_dat_do !== 32'h0000_0022) begin failures++; $display("FAIL b2b_overwrite got=%h exp=00000022", reg_dat_do); end
  endtask

  task automatic test_reset_mid_tx();
    int n;
    reg_dat_di = 32'h0000_0000;
    reg_dat_we = 1'b1;
    tick();
    reg_dat_we = 1'b0;
    repeat (3) tick();
    checks++;
    if (ser_tx !== 1'b0) begin failures++; $display("FAIL mid_tx_low got=%b exp=0", ser_tx); end
    resetn = 1'b0;
    tick();
    checks++;
    if (ser_tx !== 1'b1) begin failures++; $display("FAIL rst_ser_tx got=%b exp=1", ser_tx); end
    checks++;
    if (reg_div_do !== 32'd1) begin failures++; $display("FAIL rst_div got=%h exp=00000001", reg_div_do); end
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_rx_valid got=%h exp=ffffffff", reg_dat_do); end
    tick();
    resetn = 1'b1;
    count_busy(n);
    checks++;
    if (n != 46) begin failures++; $display("FAIL rst_dummy_wait got=%0d exp=46", n); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_div_write();
    test_div_lanes();
    test_tx();
    test_rx();
    test_back_to_back();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
